// File: rtl/beacon_mix_pkg.sv
// Shared types, default widths and the saturating adder for the beacon mixer.
package beacon_mix_pkg;

    localparam int DATA_W_DEF = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_HOLD,
        ST_RAMP_DOWN
    } ramp_state_t;

    typedef struct packed {
        logic                  sat;
        logic [DATA_W_DEF-1:0] val;
    } sat_res_t;

    // Clip a DATA_W+1 bit two's complement sum into DATA_W bits.
    // Overflow shows up as the two top bits disagreeing.
    function automatic sat_res_t sat_add(input logic [DATA_W_DEF:0] sum);
        sat_res_t r;
        r.sat = 1'b0;
        r.val = sum[DATA_W_DEF-1:0];
        if (sum[DATA_W_DEF] != sum[DATA_W_DEF-1]) begin
            r.sat = 1'b1;
            r.val = sum[DATA_W_DEF] ? {1'b1, {(DATA_W_DEF-1){1'b0}}}
                                    : {1'b0, {(DATA_W_DEF-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/beacon_gain_ramp.sv
// Gain envelope for the beacon burst: ramp up, hold at unity, ramp down.
// Also owns the generator enable and the end-of-burst pulse.
module beacon_gain_ramp
    import beacon_mix_pkg::*;
#(
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 1,
    parameter int HOLD_LEN  = 400
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            i_inject,
    output logic [GAIN_W:0] o_gain,
    output logic            o_beacon_en,
    output logic            o_done
);

    localparam int HCW = (HOLD_LEN > 1) ? $clog2(HOLD_LEN) : 1;
    localparam logic [GAIN_W:0]   FULL_G    = (GAIN_W+1)'(1 << GAIN_W);
    localparam logic [GAIN_W:0]   STEP_G    = (GAIN_W+1)'(RAMP_STEP);
    localparam logic [HCW-1:0]    HOLD_LAST = HCW'(HOLD_LEN - 1);

    ramp_state_t     r_state, w_state;
    logic [GAIN_W:0] r_gain, w_gain;
    logic [HCW-1:0]  r_hold_cnt, w_hold_cnt;
    logic            r_inject_d;
    logic            r_armed;
    logic            r_beacon_en, w_beacon_en;
    logic            r_done, w_done;

    logic [GAIN_W+1:0] w_up_sum;
    logic [GAIN_W:0]   w_gain_up;
    logic [GAIN_W:0]   w_gain_dn;
    logic              w_trigger;

    // Clamped ramp steps; the last step lands exactly on FULL or 0.
    assign w_up_sum  = {1'b0, r_gain} + {1'b0, STEP_G};
    assign w_gain_up = (w_up_sum >= {1'b0, FULL_G}) ? FULL_G : w_up_sum[GAIN_W:0];
    assign w_gain_dn = (r_gain <= STEP_G) ? '0 : (r_gain - STEP_G);

    // r_armed blocks the first cycle after reset, so an inject level that is
    // already high at reset release is seen as a level, not a rising edge.
    assign w_trigger = r_armed && i_inject && !r_inject_d;

    // State, counters and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_gain      <= '0;
            r_hold_cnt  <= '0;
            r_inject_d  <= 1'b0;
            r_armed     <= 1'b0;
            r_beacon_en <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_gain      <= w_gain;
            r_hold_cnt  <= w_hold_cnt;
            r_inject_d  <= i_inject;
            r_armed     <= 1'b1;
            r_beacon_en <= w_beacon_en;
            r_done      <= w_done;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_state     = r_state;
        w_gain      = r_gain;
        w_hold_cnt  = r_hold_cnt;
        w_beacon_en = r_beacon_en;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gain = '0;
                if (w_trigger) begin
                    w_state     = ST_RAMP_UP;
                    w_beacon_en = 1'b1;
                end
            end
            ST_RAMP_UP: begin
                if (!i_inject) begin
                    // Abort: start descending from the gain reached so far.
                    w_state = ST_RAMP_DOWN;
                end else begin
                    w_gain = w_gain_up;
                    if (w_gain_up == FULL_G) begin
                        w_state    = ST_HOLD;
                        w_hold_cnt = '0;
                    end
                end
            end
            ST_HOLD: begin
                if (!i_inject || (r_hold_cnt == HOLD_LAST)) begin
                    w_state = ST_RAMP_DOWN;
                end else begin
                    w_hold_cnt = r_hold_cnt + 1'b1;
                end
            end
            ST_RAMP_DOWN: begin
                w_gain = w_gain_dn;
                if (w_gain_dn == '0) begin
                    w_state     = ST_IDLE;
                    w_beacon_en = 1'b0;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_gain  = '0;
            end
        endcase
    end

    assign o_gain      = r_gain;
    assign o_beacon_en = r_beacon_en;
    assign o_done      = r_done;

endmodule

// File: rtl/beacon_mixer.sv
// Scales the beacon by the ramp gain and adds it to the main path with
// saturation. Output sample and clip flag are registered together.
module beacon_mixer
    import beacon_mix_pkg::*;
#(
    // sat_add is sized for the package width, so DATA_W must stay at DATA_W_DEF.
    parameter int DATA_W    = DATA_W_DEF,
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 1,
    parameter int HOLD_LEN  = 400
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     inject,
    input  logic signed [DATA_W-1:0] beacon_in,
    input  logic signed [DATA_W-1:0] signal_in,
    output logic                     beacon_en,
    output logic signed [DATA_W-1:0] mix_out,
    output logic                     sat_out,
    output logic                     done
);

    localparam int PW = DATA_W + GAIN_W + 1;

    logic [GAIN_W:0]          w_gain;
    logic signed [PW-1:0]     w_prod;
    logic [DATA_W:0]          w_scaled;
    logic [DATA_W:0]          w_sum;
    logic                     w_unused_frac;
    sat_res_t                 w_sat;
    logic signed [DATA_W-1:0] r_mix;
    logic                     r_sat;

    beacon_gain_ramp #(
        .GAIN_W    (GAIN_W),
        .RAMP_STEP (RAMP_STEP),
        .HOLD_LEN  (HOLD_LEN)
    ) u_ramp (
        .Clk         (Clk),
        .Rst         (Rst),
        .i_inject    (inject),
        .o_gain      (w_gain),
        .o_beacon_en (beacon_en),
        .o_done      (done)
    );

    // Gain is unsigned, so zero-extend it before the signed multiply.
    assign w_prod = PW'(beacon_in) * PW'($signed({1'b0, w_gain}));

    // Taking the upper bits is the arithmetic shift by GAIN_W (floor toward -inf);
    // the result always fits DATA_W+1 bits since gain never exceeds unity.
    assign w_scaled      = w_prod[PW-1:GAIN_W];
    assign w_unused_frac = ^w_prod[GAIN_W-1:0];

    assign w_sum = {signal_in[DATA_W-1], signal_in} + w_scaled;
    assign w_sat = sat_add(w_sum);

    // Output register stage: one clock from the input samples.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_mix <= '0;
            r_sat <= 1'b0;
        end else begin
            r_mix <= w_sat.val;
            r_sat <= w_sat.sat;
        end
    end

    assign mix_out = r_mix;
    assign sat_out = r_sat;

endmodule

// File: tb/tb_beacon_mixer.sv
// Bench for beacon_mixer: directed scenarios plus a randomized run, all
// checked every cycle against a behavioural burst model.
module tb_beacon_mixer;

    localparam int FULLG = 256;
    localparam int HOLD  = 400;
    localparam int MAXV  = 8388607;
    localparam int MINV  = -8388608;

    localparam int P_IDLE = 0, P_UP = 1, P_HOLD = 2, P_DOWN = 3;

    logic               Clk = 1'b0;
    logic               Rst = 1'b1;
    logic               inject = 1'b0;
    logic signed [23:0] beacon_in = '0;
    logic signed [23:0] signal_in = '0;
    logic               beacon_en;
    logic signed [23:0] mix_out;
    logic               sat_out;
    logic               done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_phase, m_gain, m_hold, m_mix;
    bit m_injd, m_armed, m_en, m_done, m_sat;

    beacon_mixer dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .inject    (inject),
        .beacon_in (beacon_in),
        .signal_in (signal_in),
        .beacon_en (beacon_en),
        .mix_out   (mix_out),
        .sat_out   (sat_out),
        .done      (done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock of the burst rules, evaluated on the inputs seen at the edge.
    task automatic model(input bit rst, input bit inj, input int b, input int s);
        longint sum;
        if (rst) begin
            m_phase = P_IDLE; m_gain = 0; m_hold = 0; m_injd = 0; m_armed = 0;
            m_en = 0; m_done = 0; m_mix = 0; m_sat = 0;
            return;
        end
        sum   = longint'(s) + ((longint'(b) * m_gain) >>> 8);
        m_sat = (sum > MAXV) || (sum < MINV);
        m_mix = (sum > MAXV) ? MAXV : (sum < MINV) ? MINV : int'(sum);
        m_done = 0;
        case (m_phase)
            P_IDLE: if (m_armed && inj && !m_injd) begin m_phase = P_UP; m_en = 1; end
            P_UP: begin
                if (!inj) m_phase = P_DOWN;
                else begin
                    m_gain = (m_gain + 1 > FULLG) ? FULLG : m_gain + 1;
                    if (m_gain == FULLG) begin m_phase = P_HOLD; m_hold = 0; end
                end
            end
            P_HOLD: if (!inj || m_hold == HOLD - 1) m_phase = P_DOWN; else m_hold++;
            default: begin
                m_gain = (m_gain - 1 < 0) ? 0 : m_gain - 1;
                if (m_gain == 0) begin m_phase = P_IDLE; m_en = 0; m_done = 1; end
            end
        endcase
        m_injd  = inj;
        m_armed = 1;
    endtask

    task automatic step(input bit rst, input bit inj, input int b, input int s);
        Rst = rst; inject = inj; beacon_in = 24'(b); signal_in = 24'(s);
        @(posedge Clk);
        model(rst, inj, b, s);
        #1;
        chk("mix", longint'(mix_out), longint'(m_mix));
        chk("sat", longint'(sat_out), longint'(m_sat));
        chk("en", longint'(beacon_en), longint'(m_en));
        chk("done", longint'(done), longint'(m_done));
    endtask

    initial begin
        int k0, t_done, ndone, run, maxrun, n, dwell;
        bit lvl, rr;
        int rb, rs;

        // Reset with inject high, then release with inject still high.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        chk("rst_mix", longint'(mix_out), 0);
        chk("rst_en", longint'(beacon_en), 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
        chk("no_trig_after_rst", longint'(beacon_en), 0);

        // Nominal burst with constant beacon.
        step(0, 0, 1920, 0);
        k0 = -1; t_done = -1; ndone = 0; run = 0; maxrun = 0;
        for (int i = 0; i < 1100; i++) begin
            step(0, i < 1000, 1920, 0);
            if (beacon_en === 1'b1 && k0 < 0) k0 = i;
            if (k0 >= 0 && i == k0 + 1) chk("nom_mix1", longint'(mix_out), 0);
            if (k0 >= 0 && i == k0 + 2) chk("nom_mix2", longint'(mix_out), 7);
            if (k0 >= 0 && i == k0 + 3) chk("nom_mix3", longint'(mix_out), 15);
            if (done === 1'b1) begin
                ndone++;
                if (t_done < 0) t_done = i;
                chk("nom_en_fall", longint'(beacon_en), 0);
            end
            if (mix_out == 1920) run++; else run = 0;
            if (run > maxrun) maxrun = run;
        end
        chk("nom_done_lat", t_done - k0, 912);
        chk("nom_done_cnt", ndone, 1);
        chk("nom_hold_run", (maxrun >= 400) ? 1 : 0, 1);

        // Saturation at full gain.
        step(0, 0, 1920, 0);
        for (int i = 0; i < 300; i++) step(0, 1, 1920, 0);
        step(0, 1, 1920, 8388000);
        chk("sat_pos_mix", longint'(mix_out), MAXV);
        chk("sat_pos_flag", longint'(sat_out), 1);
        step(0, 1, -1920, -8388000);
        chk("sat_neg_mix", longint'(mix_out), MINV);
        chk("sat_neg_flag", longint'(sat_out), 1);
        n = 0;
        while (m_phase != P_IDLE && n < 400) begin step(0, 0, 1920, 0); n++; end
        chk("sat_to_idle", m_phase, P_IDLE);

        // Floor rounding at gain 128; dropping inject freezes gain for one edge.
        step(0, 0, -3, 0);
        n = 0;
        while (m_gain != 128 && n < 300) begin step(0, 1, -3, 0); n++; end
        chk("floor_reach", m_gain, 128);
        step(0, 0, -3, 0);
        chk("floor_neg", longint'(mix_out), -2);
        step(0, 0, 3, 0);
        chk("floor_pos", longint'(mix_out), 1);
        n = 0;
        while (m_phase != P_IDLE && n < 300) begin step(0, 0, 0, 0); n++; end

        // Abort at gain 100.
        step(0, 0, 1000, 5);
        n = 0;
        while (m_gain != 100 && n < 300) begin step(0, 1, 1000, 5); n++; end
        step(0, 0, 1000, 5);
        n = 0; ndone = 0;
        while (ndone == 0 && n < 200) begin
            step(0, 0, 1000, 5); n++;
            if (done === 1'b1) ndone++;
        end
        chk("abort_len", n, 100);

        // Reset in HOLD, then re-trigger only on a fresh rising edge.
        step(0, 0, 500, 0);
        n = 0;
        while (m_phase != P_HOLD && n < 300) begin step(0, 1, 500, 0); n++; end
        for (int i = 0; i < 50; i++) step(0, 1, 500, 0);
        step(1, 1, 500, 0);
        chk("mid_rst_en", longint'(beacon_en), 0);
        chk("mid_rst_done", longint'(done), 0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 1, 500, 0);
            if (beacon_en !== 1'b0) ndone++;
        end
        chk("no_restart_level", ndone, 0);
        step(0, 0, 500, 0);
        step(0, 1, 500, 0);
        chk("retrigger_en", longint'(beacon_en), 1);
        n = 0;
        while (m_phase != P_IDLE && n < 400) begin step(0, 0, 500, 0); n++; end

        // Randomized run: random samples, random inject dwell, rare resets.
        lvl = 0; dwell = 0;
        for (int i = 0; i < 3000; i++) begin
            if (dwell == 0) begin
                lvl = ~lvl;
                dwell = $urandom_range(700, 1);
            end
            dwell--;
            rr = ($urandom_range(499, 0) == 0);
            rb = int'($signed(24'($urandom())));
            rs = int'($signed(24'($urandom())));
            if ($urandom_range(3, 0) == 0) rs = rs / 1024;
            step(rr, lvl, rb, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
